// File: rtl/aes_encrypt_engine.sv
// Iterative AES-128/192/256 encryption engine, one round per clock.
// Key and mode are captured on accept; the full round-key schedule is
// expanded combinationally from the captured key into a 1920-bit bus
// (15 x 128-bit round keys, Key[0] in the MSBs).
module aes_encrypt_engine (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

  state_t        fsm;
  logic [3:0]    round;
  logic [3:0]    nr;
  logic [127:0]  state, pt_q, rk, sr_sb, mixed;
  logic [255:0]  key_q;
  logic [1:0]    mode_q;
  logic [1919:0] round_keys;

  // GF(2^8) multiply by x, poly 0x11B
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse as a^254 (0 maps to 0), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Full 60-word schedule; words past 4*(Nr+1) are computed but never selected
  function automatic logic [1919:0] expand_key(input logic [255:0] k, input logic [1:0] md);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] bus;
    int            nk, cnt;
    nk  = (md == 2'b01) ? 6 : (md == 2'b10) ? 8 : 4;
    rc  = 8'h01;
    cnt = 0;
    bus = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 4; i < 60; i++) begin
      if (i >= nk) begin
        t = w[i-1];
        if (cnt == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && cnt == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
        cnt  = (cnt == nk - 1) ? 0 : cnt + 1;
      end
    end
    for (int i = 0; i < 60; i++) bus[1919-32*i -: 32] = w[i];
    return bus;
  endfunction

  assign round_keys = expand_key(key_q, mode_q);
  assign rk         = round_keys[1919 - 128*int'(round) -: 128];
  assign nr         = (mode_q == 2'b01) ? 4'd12 : (mode_q == 2'b10) ? 4'd14 : 4'd10;
  assign in_ready   = (fsm == IDLE);
  assign busy       = (fsm != IDLE);

  // SubBytes + ShiftRows, then MixColumns; byte n = row n%4, column n/4
  always_comb begin
    sr_sb = '0;
    mixed = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr_sb[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = sr_sb[127-32*c -: 8];
      a1 = sr_sb[119-32*c -: 8];
      a2 = sr_sb[111-32*c -: 8];
      a3 = sr_sb[103-32*c -: 8];
      mixed[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
  end

  // Control FSM: accept, whitening, Nr rounds, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      round      <= '0;
      state      <= '0;
      pt_q       <= '0;
      key_q      <= '0;
      mode_q     <= '0;
      ciphertext <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          pt_q   <= plaintext;
          key_q  <= key;
          mode_q <= mode;
          fsm    <= INIT;
        end
        INIT: begin
          state <= pt_q ^ rk;
          round <= 4'd1;
          fsm   <= ROUND;
        end
        ROUND: if (round == nr) begin
          ciphertext <= sr_sb ^ rk;
          out_valid  <= 1'b1;
          round      <= '0;
          fsm        <= DONE;
        end else begin
          state <= mixed ^ rk;
          round <= round + 4'd1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
